// File: rtl/spir_pkg.sv
// -----------------------------------------------------------------------------
// spir_pkg
// Shared definitions for the ADC SPI read master (spir_adc_rx).
//   - State encodings for the read FSM, including the two null-bit states that
//     only exist when SPIR_NULL_BIT_EN is defined.
//   - Default frame width and dclk half-period divider.
//   - Width helper for the bit counter.
// No ports.
// -----------------------------------------------------------------------------
package spir_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_HIGH   = 3'd2;
    localparam logic [2:0] S_LOW    = 3'd3;
    localparam logic [2:0] S_CSH    = 3'd4;
    localparam logic [2:0] S_NULL_H = 3'd5;
    localparam logic [2:0] S_NULL_L = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_SETUP  = S_SETUP,
        ST_HIGH   = S_HIGH,
        ST_LOW    = S_LOW,
        ST_CSH    = S_CSH,
        ST_NULL_H = S_NULL_H,
        ST_NULL_L = S_NULL_L
    } spir_state_t;

    // The counter has to hold the value DATA_W itself, hence the +1.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spir_adc_rx_if.sv
// -----------------------------------------------------------------------------
// spir_adc_rx_if
// Bundles the request, ADC serial lines and result signals of spir_adc_rx.
//   strr        start-read request (level, honoured only while idle)
//   miso        ADC serial data, already synchronised
//   cs          ADC chip select, active low
//   dclk        ADC serial clock, idle low
//   data        last completed word
//   valid       one-cycle pulse when data updates
//   eor         end-of-read / ready, high only while idle
//   nullbit_err null-bit check failure (0 when SPIR_NULL_BIT_EN is undefined)
// Modports: master = the read block, slave = the user/ADC side.
// -----------------------------------------------------------------------------
interface spir_adc_rx_if
    import spir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              strr;
    logic              miso;
    logic              cs;
    logic              dclk;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              eor;
    logic              nullbit_err;

    modport master (
        input  strr, miso,
        output cs, dclk, data, valid, eor, nullbit_err
    );

    modport slave (
        output strr, miso,
        input  cs, dclk, data, valid, eor, nullbit_err
    );
endinterface

// File: rtl/spir_tick_gen.sv
// -----------------------------------------------------------------------------
// spir_tick_gen
// Half-period divider for the ADC serial clock. div_cnt runs 0..CLK_DIV-1 and
// tick marks its last value; clr restarts the count so that every FSM state
// begins at 0 and lasts exactly CLK_DIV cycles.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous, active-high reset
//   clr_i   restart strobe (FSM state change)
//   tick_o  high in the last cycle of a half-period
// Parameter: CLK_DIV (>= 2) clk_i cycles per half-period.
// -----------------------------------------------------------------------------
module spir_tick_gen
    import spir_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
        end else if (clr_i || (div_cnt == LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick_o = (div_cnt == LAST);
endmodule

// File: rtl/spir_adc_rx.sv
// -----------------------------------------------------------------------------
// spir_adc_rx
// SPI read master for the external ADC. Clocks DATA_W bits out of the ADC on
// MISO, MSB first, and presents them as a parallel word with a one-cycle
// valid pulse. All outputs are registered.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous, active-high reset
//   bus    spir_adc_rx_if.master (strr, miso in; cs, dclk, data, valid, eor,
//          nullbit_err out)
// Parameters: DATA_W (2..32) bits per frame, CLK_DIV (>= 2) clk_i cycles per
// dclk half-period.
// Build option: SPIR_NULL_BIT_EN adds a leading null-bit dclk period whose
// sample must read 0; otherwise nullbit_err is tied low.
//
// state  | meaning
// IDLE   | cs high, ready; start on strr
// SETUP  | cs low, dclk low; chip-select setup time
// NULL_H | dclk high for the null bit; sampled on tick (option only)
// NULL_L | dclk low after the null bit (option only)
// HIGH   | dclk high; miso shifted in on the last cycle before the fall
// LOW    | dclk low; ADC moves to the next bit
// CSH    | cs high; chip-select hold time, result published on tick
// -----------------------------------------------------------------------------
module spir_adc_rx
    import spir_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    spir_adc_rx_if.master bus
);
    localparam int BC_W = bit_cnt_w(DATA_W);

    spir_state_t       state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              cs_q, cs_d;
    logic              dclk_q, dclk_d;
    logic              eor_q, eor_d;
    logic              done;
    logic              tick;
    logic              state_chg;

`ifdef SPIR_NULL_BIT_EN
    logic              null_smp_q, null_smp_d;
    logic              nerr_q;
`endif

    assign state_chg = (state_d != state_q);

    spir_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cs_q      <= 1'b1;
            dclk_q    <= 1'b0;
            eor_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            valid_q   <= done;
            cs_q      <= cs_d;
            dclk_q    <= dclk_d;
            eor_q     <= eor_d;
            if (done) begin
                data_q <= shreg_q;
            end
        end
    end

`ifdef SPIR_NULL_BIT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            null_smp_q <= 1'b0;
            nerr_q     <= 1'b0;
        end else begin
            null_smp_q <= null_smp_d;
            if (done) begin
                nerr_q <= null_smp_q;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        done      = 1'b0;
`ifdef SPIR_NULL_BIT_EN
        null_smp_d = null_smp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.strr) begin
                    bit_cnt_d = '0;
                    shreg_d   = '0;
`ifdef SPIR_NULL_BIT_EN
                    null_smp_d = 1'b0;
`endif
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
`ifdef SPIR_NULL_BIT_EN
                    state_d = ST_NULL_H;
`else
                    state_d = ST_HIGH;
`endif
                end
            end
`ifdef SPIR_NULL_BIT_EN
            ST_NULL_H: begin
                if (tick) begin
                    null_smp_d = bus.miso;
                    state_d    = ST_NULL_L;
                end
            end
            ST_NULL_L: begin
                if (tick) begin
                    state_d = ST_HIGH;
                end
            end
`endif
            ST_HIGH: begin
                if (tick) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], bus.miso};
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    state_d = (bit_cnt_q == BC_W'(DATA_W)) ? ST_CSH : ST_HIGH;
                end
            end
            ST_CSH: begin
                if (tick) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line levels follow the state being entered so the registered outputs
    // line up with the state register.
    always_comb begin
        cs_d   = 1'b0;
        dclk_d = 1'b0;
        eor_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                cs_d  = 1'b1;
                eor_d = 1'b1;
            end
            ST_CSH: begin
                cs_d = 1'b1;
            end
            ST_HIGH: begin
                dclk_d = 1'b1;
            end
`ifdef SPIR_NULL_BIT_EN
            ST_NULL_H: begin
                dclk_d = 1'b1;
            end
`endif
            default: begin
                cs_d = 1'b0;
            end
        endcase
    end

    assign bus.cs    = cs_q;
    assign bus.dclk  = dclk_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.eor   = eor_q;
`ifdef SPIR_NULL_BIT_EN
    assign bus.nullbit_err = nerr_q;
`else
    assign bus.nullbit_err = 1'b0;
`endif
endmodule
